// File: rtl/add_one_incrementer.sv
// rtl/add_one_incrementer.sv - unsigned x+1 incrementer with combinational and registered outputs
module add_one_incrementer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    input  logic             in_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             wrap_sticky
);

    // One extra bit so the wrap shows up as the top bit of the sum.
    logic [WIDTH:0] sum;

    // Zero-latency increment; the carry out is the wrap indication.
    always_comb begin
        sum = {1'b0, x} + (WIDTH+1)'(1);
    end

    assign y     = sum[WIDTH-1:0];
    assign carry = sum[WIDTH];

    // Registered copy of the result, only updated on a qualified operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else if (in_valid) begin
            y_q <= sum[WIDTH-1:0];
        end
    end

    // Valid follows in_valid by one cycle; no backpressure exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Sticky wrap flag; clear wins over a wrap seen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_sticky <= 1'b0;
        end else if (clear) begin
            wrap_sticky <= 1'b0;
        end else if (in_valid && carry) begin
            wrap_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_add_one_incrementer.sv
// tb/tb_add_one_incrementer.sv - scoreboard bench for add_one_incrementer
module tb_add_one_incrementer;

    localparam int W   = 9;
    localparam int MOD = 512;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         carry;
    logic         in_valid;
    logic         clear;
    logic [W-1:0] y_q;
    logic         out_valid;
    logic         wrap_sticky;

    int checks   = 0;
    int failures = 0;

    int q_exp[$];
    int exp_yq     = 0;
    int exp_valid  = 0;
    int exp_sticky = 0;
    bit mon_en     = 0;

    add_one_incrementer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .carry       (carry),
        .in_valid    (in_valid),
        .clear       (clear),
        .y_q         (y_q),
        .out_valid   (out_valid),
        .wrap_sticky (wrap_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Combinational reference: plain modular arithmetic.
    task automatic chk_comb(input string tag);
        int xv;
        xv = int'(x);
        chk({tag, "_y"}, 32'(y), 32'((xv + 1) % MOD));
        chk({tag, "_carry"}, 32'(carry), 32'(xv == MOD - 1));
    endtask

    // One clock cycle of stimulus; the model advances on the edge.
    task automatic cycle(input bit v, input int xv, input bit clr);
        in_valid = v;
        x        = W'(xv);
        clear    = clr;
        #1;
        chk_comb("cyc");
        @(posedge clk);
        if (rst_n) begin
            if (v) begin
                exp_yq = (xv + 1) % MOD;
                q_exp.push_back(exp_yq);
            end
            exp_valid = v;
            if (clr) exp_sticky = 0;
            else if (v && xv == MOD - 1) exp_sticky = 1;
        end
        @(negedge clk);
    endtask

    // Monitor: compares registered outputs against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("wrap_sticky", 32'(wrap_sticky), 32'(exp_sticky));
            chk("y_q_held", 32'(y_q), 32'(exp_yq));
            if (out_valid === 1'b1) begin
                if (q_exp.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    chk("y_q_sb", 32'(y_q), 32'(q_exp.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xv;
        rst_n    = 1'b0;
        x        = '0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #3;
        chk("rst_y_q", 32'(y_q), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sticky", 32'(wrap_sticky), 32'd0);
        chk_comb("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;

        // Stride sweep, combinational only.
        xv = 0;
        for (int i = 0; i < 256; i++) begin
            x = W'(xv);
            #1;
            chk_comb("sweep");
            xv = (xv + 17) % MOD;
        end

        // Wrap boundaries.
        x = W'(511); #1; chk_comb("wrap511");
        x = W'(510); #1; chk_comb("wrap510");
        @(negedge clk);

        // Registered path and sticky flag.
        cycle(1, 100, 0);
        cycle(0, 5, 0);
        cycle(1, 511, 0);
        cycle(1, 3, 0);
        cycle(1, 3, 0);
        cycle(1, 511, 1);
        cycle(1, 511, 0);
        cycle(1, 100, 0);

        // Asynchronous reset between edges with y_q=101, out_valid=1, sticky=1.
        in_valid = 1'b1;
        x        = W'(511);
        #2;
        rst_n      = 1'b0;
        exp_yq     = 0;
        exp_valid  = 0;
        exp_sticky = 0;
        q_exp.delete();
        #1;
        chk("arst_y_q", 32'(y_q), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sticky", 32'(wrap_sticky), 32'd0);
        chk_comb("arst");
        @(negedge clk);
        cycle(1, 511, 0);
        cycle(1, 42, 0);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int rx;
            rx = ($urandom_range(0, 7) == 0) ? 511 : int'($urandom_range(0, 511));
            cycle(1'($urandom_range(0, 1)), rx, ($urandom_range(0, 9) == 0));
        end
        cycle(0, 0, 0);

        // Exhaustive combinational check.
        for (int i = 0; i < MOD; i++) begin
            x = W'(i);
            #1;
            chk_comb("exh");
        end

        @(negedge clk);
        chk("sb_empty", 32'(q_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_one_incrementer.md
Name: add_one_incrementer

Overview:
Unsigned incrementer: a combinational path drives y = x + 1 with zero latency. A clocked side path provides a registered copy of the result, a valid flag and a sticky wrap flag for pipelined consumers. It is a leaf arithmetic block used wherever a value plus one is needed, either in the same cycle or one cycle later.

Parameters:
WIDTH, 9, data width of x, y and y_q in bits (minimum 1).

Ports:
clk  input  1  rising-edge clock for the registered path only
rst_n  input  1  asynchronous active-low reset for the registered path
x  input  WIDTH  unsigned operand
y  output  WIDTH  combinational result, (x + 1) mod 2^WIDTH
carry  output  1  combinational, 1 when x is all-ones (the result wraps)
in_valid  input  1  qualifies x for the registered path
clear  input  1  synchronous clear of wrap_sticky
y_q  output  WIDTH  registered (x + 1) mod 2^WIDTH, captured when in_valid=1
out_valid  output  1  registered copy of in_valid
wrap_sticky  output  1  set once any captured operand wrapped; held until cleared

Behaviour:
- Combinational path:
  - y and carry are purely combinational from x.
  - y and carry are independent of clk, rst_n, in_valid and clear.
  - They must settle within the same simulation time step that x changes; no registers and no latches on this path.
- Arithmetic:
  - Internally form a WIDTH+1-bit sum {carry, y} = x + 1.
  - x = 2^WIDTH - 1 gives y = 0, carry = 1; every other x gives carry = 0.
  - No X propagation from known inputs.
- Registered path, on the rising edge of clk:
  - If in_valid = 1, y_q <= (x + 1) mod 2^WIDTH; otherwise y_q holds its value.
  - out_valid <= in_valid.
  - wrap_sticky <= 0 if clear = 1.
  - Else wrap_sticky <= 1 if in_valid = 1 and carry = 1.
  - Else wrap_sticky holds.
  - clear has priority over a simultaneous wrap.
- Latency: y and carry are 0 cycles; y_q and out_valid are 1 cycle.
- Reset:
  - rst_n low asynchronously forces y_q = 0, out_valid = 0 and wrap_sticky = 0, immediately and independent of clk.
  - Registers stay at these values while rst_n is low.
  - Reset deassertion is sampled on the next rising clk edge, where normal operation resumes.
  - Reset never affects y or carry.
- Back-to-back in_valid every cycle is supported; there is no backpressure.

Test Plan:
- Sweep, WIDTH=9, reset released: x = 0, then x += 17 mod 512 for 256 steps; check after each change (within 1 time unit, before any clock edge) that y == x+1 and carry == 0. Example values: x=0 -> y=1, x=17 -> 18, x=34 -> 35.
- Wrap: x = 511 -> y = 0, carry = 1. x = 510 -> y = 511, carry = 0.
- Registered path:
  - in_valid=1 with x = 100, then a clk edge -> y_q = 101, out_valid = 1.
  - Next cycle in_valid=0 with x = 5 -> y_q stays 101, out_valid = 0, while y = 6 immediately.
- Sticky flag:
  - in_valid=1 with x=511, then an edge -> wrap_sticky = 1, y_q = 0.
  - Later captures with x=3 -> wrap_sticky stays 1.
  - clear=1 together with in_valid=1 and x=511 for one edge -> wrap_sticky = 0.
- Async reset mid-operation: with y_q = 101, out_valid = 1 and wrap_sticky = 1, pull rst_n low between clock edges.
  - Required immediately: y_q = 0, out_valid = 0, wrap_sticky = 0.
  - Required throughout: y still tracks x+1.
- Exhaustive combinational check, WIDTH=9: all 512 values of x -> y == (x+1) mod 512 and carry == (x == 511).
